// File: rtl/byte_mem_ctrl.sv
// Byte-addressed unified instruction/data memory with registered reads, write-first
// fetch forwarding, register-backed peripheral mailbox words and a post-reset scrub.
module byte_mem_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int BYTE_WIDTH = 8,
    parameter int DATA_BYTES = 2,
    parameter int INST_BYTES = 4,
    parameter int PERIPH_CH  = 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      inst_req,
    input  logic [ADDR_WIDTH-1:0]                     inst_addr,
    output logic                                      inst_valid,
    output logic [INST_BYTES*BYTE_WIDTH-1:0]          inst_data,
    input  logic                                      data_req,
    input  logic                                      data_we,
    input  logic [DATA_BYTES-1:0]                     data_be,
    input  logic [ADDR_WIDTH-1:0]                     data_addr,
    input  logic [DATA_BYTES*BYTE_WIDTH-1:0]          data_wdata,
    output logic                                      data_ready,
    output logic                                      data_rvalid,
    output logic [DATA_BYTES*BYTE_WIDTH-1:0]          data_rdata,
    output logic [PERIPH_CH*DATA_BYTES*BYTE_WIDTH-1:0] periph_bus,
    output logic [PERIPH_CH-1:0]                      periph_upd,
    output logic                                      dbgState
);
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int MBOX_BYTES = PERIPH_CH * DATA_BYTES;
    localparam int MBOX_IW    = (MBOX_BYTES > 1) ? $clog2(MBOX_BYTES) : 1;
    localparam logic [ADDR_WIDTH-1:0] MBOX_BASE = ADDR_WIDTH'(DEPTH - MBOX_BYTES);

    // Handshake: the data port accepts a request in any cycle where data_ready is high
    // (no backpressure in RUN); read results appear with a 1-cycle valid pulse.
    typedef enum logic {SCRUB = 1'b0, RUN = 1'b1} state_e;

    state_e state, nextState;
    logic [ADDR_WIDTH-1:0] scrubCnt;
    logic [BYTE_WIDTH-1:0] mem  [DEPTH];
    logic [BYTE_WIDTH-1:0] mbox [MBOX_BYTES];

    logic running, storeEn, loadEn, fetchEn;
    logic [ADDR_WIDTH-1:0] fetchAddr [INST_BYTES];
    logic [ADDR_WIDTH-1:0] dataAddr  [DATA_BYTES];
    logic [INST_BYTES*BYTE_WIDTH-1:0] fetchWord;
    logic [DATA_BYTES*BYTE_WIDTH-1:0] loadWord;
    logic [PERIPH_CH-1:0] updHit;

    function automatic logic [MBOX_IW-1:0] mboxIdx(input logic [ADDR_WIDTH-1:0] a);
        return MBOX_IW'(a - MBOX_BASE);
    endfunction

    assign running    = (state == RUN);
    assign storeEn    = running & data_req & data_we;
    assign loadEn     = running & data_req & ~data_we;
    assign fetchEn    = running & inst_req;
    assign data_ready = running;
    assign dbgState   = running;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SCRUB;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (state == SCRUB && scrubCnt == '1) nextState = RUN;
    end

    always_comb begin
        for (int i = 0; i < INST_BYTES; i++) fetchAddr[i] = inst_addr + ADDR_WIDTH'(i);
        for (int j = 0; j < DATA_BYTES; j++) dataAddr[j] = data_addr + ADDR_WIDTH'(j);
    end

    // Fetch bytes hit by an enabled store in the same cycle take the new store data.
    always_comb begin
        fetchWord = '0;
        for (int i = 0; i < INST_BYTES; i++) begin
            if (fetchAddr[i] >= MBOX_BASE)
                fetchWord[i*BYTE_WIDTH +: BYTE_WIDTH] = mbox[mboxIdx(fetchAddr[i])];
            else
                fetchWord[i*BYTE_WIDTH +: BYTE_WIDTH] = mem[fetchAddr[i]];
            for (int j = 0; j < DATA_BYTES; j++)
                if (storeEn && data_be[j] && dataAddr[j] == fetchAddr[i])
                    fetchWord[i*BYTE_WIDTH +: BYTE_WIDTH] = data_wdata[j*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    always_comb begin
        loadWord = '0;
        for (int j = 0; j < DATA_BYTES; j++) begin
            if (dataAddr[j] >= MBOX_BASE)
                loadWord[j*BYTE_WIDTH +: BYTE_WIDTH] = mbox[mboxIdx(dataAddr[j])];
            else
                loadWord[j*BYTE_WIDTH +: BYTE_WIDTH] = mem[dataAddr[j]];
        end
    end

    // Mailbox byte r belongs to channel PERIPH_CH-1-r/DATA_BYTES (channel 0 is topmost).
    always_comb begin
        updHit = '0;
        for (int k = 0; k < PERIPH_CH; k++)
            for (int j = 0; j < DATA_BYTES; j++)
                if (storeEn && data_be[j] && dataAddr[j] >= MBOX_BASE &&
                    (PERIPH_CH - 1 - int'(mboxIdx(dataAddr[j])) / DATA_BYTES) == k)
                    updHit[k] = 1'b1;
    end

    always_comb begin
        periph_bus = '0;
        for (int k = 0; k < PERIPH_CH; k++)
            for (int j = 0; j < DATA_BYTES; j++)
                periph_bus[(k*DATA_BYTES + j)*BYTE_WIDTH +: BYTE_WIDTH] =
                    mbox[(PERIPH_CH - 1 - k)*DATA_BYTES + j];
    end

    // The array itself is never reset; only the scrub pass clears it.
    always_ff @(posedge clk) begin
        if (state == SCRUB) begin
            mem[scrubCnt] <= '0;
        end else if (storeEn) begin
            for (int j = 0; j < DATA_BYTES; j++)
                if (data_be[j] && dataAddr[j] < MBOX_BASE)
                    mem[dataAddr[j]] <= data_wdata[j*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scrubCnt    <= '0;
            inst_valid  <= 1'b0;
            inst_data   <= '0;
            data_rvalid <= 1'b0;
            data_rdata  <= '0;
            periph_upd  <= '0;
            for (int r = 0; r < MBOX_BYTES; r++) mbox[r] <= '0;
        end else begin
            if (state == SCRUB) scrubCnt <= scrubCnt + ADDR_WIDTH'(1);
            inst_valid  <= fetchEn;
            data_rvalid <= loadEn;
            periph_upd  <= updHit;
            if (fetchEn) inst_data <= fetchWord;
            if (loadEn)  data_rdata <= loadWord;
            if (storeEn)
                for (int j = 0; j < DATA_BYTES; j++)
                    if (data_be[j] && dataAddr[j] >= MBOX_BASE)
                        mbox[mboxIdx(dataAddr[j])] <= data_wdata[j*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end
endmodule

// File: doc/byte_mem_ctrl.md
Name: byte_mem_ctrl

Overview:
- Parametrised successor to the processor's unified byte-addressed instruction/data memory.
- Provides:
  - an instruction fetch port (INST_BYTES wide) and a data load/store port (DATA_BYTES wide, with byte enables);
  - PERIPH_CH register-backed peripheral mailbox words at the top of the address space.
- Reads are registered (1-cycle latency) with valid strobes.
- After reset, a scrub FSM zeroes the whole array before the ports are opened.

Parameters:
- ADDR_WIDTH, 16, byte address width; array depth 2^ADDR_WIDTH bytes.
- BYTE_WIDTH, 8, bits per addressable byte.
- DATA_BYTES, 2, bytes per data-port access.
- INST_BYTES, 4, bytes per instruction fetch.
- PERIPH_CH, 1, number of DATA_BYTES-wide peripheral mailbox words.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst_req  in  1  fetch request.
- inst_addr  in  ADDR_WIDTH  fetch byte address (any alignment).
- inst_valid  out  1  fetch data valid (1-cycle pulse).
- inst_data  out  INST_BYTES*BYTE_WIDTH  fetched bytes, little-endian.
- data_req  in  1  data access request.
- data_we  in  1  1 = store, 0 = load.
- data_be  in  DATA_BYTES  store byte enables, bit i applies to byte addr+i.
- data_addr  in  ADDR_WIDTH  data byte address (any alignment).
- data_wdata  in  DATA_BYTES*BYTE_WIDTH  store data, little-endian.
- data_ready  out  1  port accepting requests.
- data_rvalid  out  1  load data valid (1-cycle pulse).
- data_rdata  out  DATA_BYTES*BYTE_WIDTH  load data, little-endian.
- periph_bus  out  PERIPH_CH*DATA_BYTES*BYTE_WIDTH  mailbox contents, channel k at [k*DATA_BYTES*BYTE_WIDTH +: DATA_BYTES*BYTE_WIDTH].
- periph_upd  out  PERIPH_CH  bit k pulses 1 cycle after a store modifies any byte of channel k.

Behaviour:
- Byte mapping:
  - Access byte i lives at (addr + i) mod 2^ADDR_WIDTH, so accesses wrap around the top of memory.
  - Byte i occupies bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- Mailbox region:
  - Channel k base address = 2^ADDR_WIDTH - (k+1)*DATA_BYTES (channel 0 is the topmost word).
  - Mailbox bytes are held in registers, not the array; reads and fetches of those addresses return the register contents.
  - periph_bus is driven directly from these registers.
- FSM, two states:
  - SCRUB:
    - Entered on reset.
    - An ADDR_WIDTH-bit counter writes 0 to array[cnt] every cycle, 0 to 2^ADDR_WIDTH-1.
    - data_ready = 0; inst_req and data_req are ignored.
    - After the cycle that writes the last address → RUN.
  - RUN:
    - data_ready = 1.
    - No exit except reset.
- Reset (async assert, any state, including mid-scrub):
  - State=SCRUB, counter=0.
  - All outputs 0: inst_valid, inst_data, data_ready, data_rvalid, data_rdata, periph_upd.
  - Mailbox registers = 0.
  - Pending read strobes are dropped.
  - Scrub restarts from address 0 after release.
- Fetch (RUN, inst_req=1):
  - inst_data is registered at the edge; inst_valid = 1 the next cycle.
  - inst_data holds its value until the next fetch.
- Load (RUN, data_req=1, data_we=0):
  - data_rdata is registered; data_rvalid = 1 the next cycle.
  - data_rdata holds until the next load.
  - data_be is ignored for loads.
- Store (RUN, data_req=1, data_we=1):
  - Only bytes with data_be[i]=1 are written, array or mailbox.
  - No rvalid.
  - periph_upd[k] pulses the next cycle if any enabled byte falls in channel k.
  - periph_bus reflects the new value the same cycle that periph_upd is high.
- Write-first forwarding: a fetch issued in the same cycle as a store returns the newly stored bytes for every overlapping enabled byte. Non-overlapping bytes return the old contents.
- Back-to-back: one request per port per cycle, no bubbles.
- Read-after-write on the data port in the next cycle returns the new value.
- Array contents are not reset; only the scrub clears them.

Test Plan (ADDR_WIDTH=6, PERIPH_CH=2: ch0 = bytes 62..63, ch1 = bytes 60..61):
- Release reset → data_ready low exactly 64 cycles, then high. Load addr 0x05 → data_rvalid next cycle, data_rdata=0x0000. periph_bus=0.
- Store 0x10 = 0xBEEF with be=11, then store 0x10 = 0x1234 with be=01 → load 0x10 = 0xBE34. Fetch 0x0F = 0x00BE3400.
- Store addr 0x3B = 0xA1B2 with be=11 → next cycle periph_upd=2'b10, ch1 word = 0x00A1, array[0x3B]=0xB2. Store 0x3E = 0x5566 → periph_upd=2'b01, ch0=0x5566.
- Wrap: with array[0]=0x11 and array[1]=0x22 and ch0=0x5566, fetch 0x3E → inst_data=0x22115566.
- Same cycle: store 0x20 = 0xCAFE (be=10) plus fetch 0x20 → inst_data=0x0000CA00.
- Assert rst_n=0 at scrub count 20, and separately one cycle after a load → outputs 0 immediately, no rvalid pulse, and data_ready low for a full 64 cycles after release.
